palette_bank_lut: RTL
=====================

# palette_bank_lut

Writable, multi-bank colour palette for the sprite and tile drawing path. It maps a bank number and a colour index to 4-bit RGB through a two-stage registered pipeline. A frame-synchronous brightness fade engine scales every output colour. It sits between the sprite/tile index fetch and the VGA colour mux, and replaces the fixed per-sprite palette ROMs: the game logic loads palettes at run time.

## Interface
- `IDX_W`, 5: colour index width; each bank holds 2^IDX_W entries.
- `BANK_W`, 2: bank select width; there are 2^BANK_W banks.
- `COLOR_W`, 4: bits per colour channel.
- `TRANSP_IDX`, 0: index reported as transparent.
- `FADE_DIV`, 4: number of `frame_tick` pulses per fade step.

Ports:
- `Clk`  in  1  system clock; all logic rises on this edge.
- `Reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  palette write strobe.
- `wr_bank`  in  BANK_W  write bank.
- `wr_index`  in  IDX_W  write entry.
- `wr_rgb`  in  3*COLOR_W  write data, ordered {R,G,B}.
- `rd_valid_in`  in  1  lookup request qualifier.
- `rd_bank`  in  BANK_W  lookup bank.
- `rd_index`  in  IDX_W  lookup entry.
- `rd_valid_out`  out  1  output qualifier.
- `red`, `green`, `blue`  out  COLOR_W each  scaled colour.
- `transparent`  out  1  high when the looked-up index equals TRANSP_IDX.
- `frame_tick`  in  1  one-cycle pulse per frame (vsync edge).
- `fade_start`  in  1  load a new fade target.
- `fade_target`  in  5  target brightness level, 0..16.
- `fade_busy`  out  1  high while the current level differs from the target.
- `init_busy`  out  1  high while the clear sweep is running.

## Operation
- Storage is 2^(BANK_W+IDX_W) words of 3*COLOR_W bits. Address = {bank, index}.
- Control FSM states:
  - INIT: entered on Reset. Writes zero to one address per cycle, starting at 0 and ascending. `init_busy` is high. Writes from `wr_en` are ignored. After the last address has been cleared the FSM moves to RUN.
  - RUN: `wr_en` writes `wr_rgb` to {wr_bank, wr_index}.
- Read pipeline:
  - Stage 1 registers the stored word, `rd_valid_in` and the transparency compare.
  - Stage 2 registers each channel as (c*level)>>4, where c is COLOR_W bits and level is 5 bits. The intermediate is COLOR_W+5 bits wide; the result is truncated to COLOR_W. Level 16 is the identity; level 0 gives black.
  - Reads are accepted in both states. During INIT they return the current RAM contents, which may be partially cleared.
- Fade engine:
  - Holds `level` (reset value 16), `target` (reset value 16) and a frame counter (reset value 0).
  - `fade_start` in RUN latches `fade_target`, clamped to 16. The frame counter is not cleared.
  - Each `frame_tick` while level≠target increments the frame counter. When the counter reaches FADE_DIV-1, it wraps to 0 and level steps by 1 toward target.
  - While level==target the counter is held at 0.
  - `fade_busy` = (level≠target).
  - `fade_start` during INIT is ignored.
- If `fade_start` and the final step's `frame_tick` occur in the same cycle, the step is applied using the old target, then the new target is latched.

## Timing
- Read latency is exactly 2 cycles: a request at cycle N appears on outputs at N+2. Full throughput, one lookup per cycle, with no stalls.
- Read and write to the same address in the same cycle return the old data (read-before-write). The new data is visible to a read issued at N+1.
- A level change takes effect on lookups that enter stage 2 on the cycle after the step.
- Reset values of outputs: `rd_valid_out`=0, `red`/`green`/`blue`=0, `transparent`=0, `fade_busy`=0, `init_busy`=1.
- INIT length is 2^(BANK_W+IDX_W) cycles after Reset deasserts; this is 128 for the defaults. `init_busy` falls on the cycle after the final clear write.
- Reset asserted mid-INIT or mid-fade: the FSM restarts INIT at address 0, level and target return to 16, and the pipeline valids clear on the next edge.

## Configuration
- `PALETTE_FADE_EN` defined: the fade engine and the stage-2 multiplier are present as described above.
- `PALETTE_FADE_EN` not defined:
  - Stage 2 is a plain register and level is fixed at 16.
  - `fade_start`, `fade_target` and `frame_tick` are ignored, and `fade_busy` is tied to 0.
  - Latency stays at 2 cycles.

## Test plan
- Reset, then hold idle. Required: `init_busy` high for 128 cycles and then 0. A subsequent read of every {bank, index} returns rgb 000 with `rd_valid_out` exactly 2 cycles after `rd_valid_in`.
- Write bank 2, index 7 with rgb F E 9, then read bank 2, index 7 and bank 1, index 7. Required: outputs F/E/9, then 0/0/0. `transparent`=0 for both reads; reading index 0 gives `transparent`=1.
- In the same cycle, write bank 0, index 3 with rgb A 9 6 and read bank 0, index 3. Required: returns 000. A read on the next cycle returns A/9/6.
- Entry F,E,9, `fade_start` with target 8, FADE_DIV=4. Required: `fade_busy` stays 1 for 32 `frame_tick`s, level steps every 4 ticks, and the final output is 7/7/4. A target of 20 clamps to 16 and gives no change.
- Assert Reset at cycle 50 of INIT and mid-fade. Required: `init_busy` restarts a full 128-cycle sweep, level returns to 16, `fade_busy` is 0, and `rd_valid_out` is 0.
- Build without `PALETTE_FADE_EN`, pulse `fade_start` with target 0 plus ticks. Required: colours are unscaled and `fade_busy` stays 0.

Source files
------------

// File: rtl/palette_bank_lut_if.sv
// Palette bus: write port, lookup request/response and fade controls.
interface palette_bank_lut_if #(
    parameter int IDX_W   = 5,
    parameter int BANK_W  = 2,
    parameter int COLOR_W = 4
);
    logic                   wr_en;
    logic [BANK_W-1:0]      wr_bank;
    logic [IDX_W-1:0]       wr_index;
    logic [3*COLOR_W-1:0]   wr_rgb;
    logic                   rd_valid_in;
    logic [BANK_W-1:0]      rd_bank;
    logic [IDX_W-1:0]       rd_index;
    logic                   rd_valid_out;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   transparent;
    logic                   frame_tick;
    logic                   fade_start;
    logic [4:0]             fade_target;
    logic                   fade_busy;
    logic                   init_busy;

    modport master (
        output wr_en, wr_bank, wr_index, wr_rgb,
        output rd_valid_in, rd_bank, rd_index,
        output frame_tick, fade_start, fade_target,
        input  rd_valid_out, red, green, blue, transparent, fade_busy, init_busy
    );

    modport slave (
        input  wr_en, wr_bank, wr_index, wr_rgb,
        input  rd_valid_in, rd_bank, rd_index,
        input  frame_tick, fade_start, fade_target,
        output rd_valid_out, red, green, blue, transparent, fade_busy, init_busy
    );
endinterface

// File: rtl/palette_bank_lut.sv
// Multi-bank writable palette with 2-stage lookup and frame-synchronous fade.
// Optional fade engine enabled by defining PALETTE_FADE_EN.
module palette_bank_lut #(
    parameter int IDX_W      = 5,
    parameter int BANK_W     = 2,
    parameter int COLOR_W    = 4,
    parameter int TRANSP_IDX = 0,
    parameter int FADE_DIV   = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    palette_bank_lut_if.slave  bus
);
    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RGB_W  = 3 * COLOR_W;
    localparam int STAGES = 2;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [RGB_W-1:0]    mem_wdata;
    logic [RGB_W-1:0]    mem [DEPTH];

    logic [RGB_W-1:0]    s1_rgb;
    logic                s1_transp;
    logic [STAGES:1]     vld_pipe;
    logic                transp_q;
    logic [2:0][COLOR_W-1:0] s2_rgb;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_INIT;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // The clear sweep owns the write port; user writes only land in RUN.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        mem_we       = 1'b0;
        mem_waddr    = {bus.wr_bank, bus.wr_index};
        mem_wdata    = bus.wr_rgb;
        case (state)
            S_INIT: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_addr;
                mem_wdata    = '0;
                clr_addr_nxt = clr_addr + 1'b1;
                if (clr_addr == ADDR_W'(DEPTH - 1))
                    state_nxt = S_RUN;
            end
            S_RUN:   mem_we = bus.wr_en;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (mem_we && !Reset)
            mem[mem_waddr] <= mem_wdata;
    end

    // Registered read gives read-before-write on a same-address collision.
    always_ff @(posedge Clk) begin
        s1_rgb <= mem[{bus.rd_bank, bus.rd_index}];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe  <= '0;
            s1_transp <= 1'b0;
            transp_q  <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], bus.rd_valid_in};
            s1_transp <= (bus.rd_index == IDX_W'(TRANSP_IDX));
            transp_q  <= s1_transp;
        end
    end

`ifdef PALETTE_FADE_EN
    localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [4:0]       level, target;
    logic [CNT_W-1:0] fcnt;

    // Step uses the old target; a same-cycle fade_start lands afterwards.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            level  <= 5'd16;
            target <= 5'd16;
            fcnt   <= '0;
        end else begin
            if (level == target) begin
                fcnt <= '0;
            end else if (bus.frame_tick) begin
                if (fcnt == CNT_W'(FADE_DIV - 1)) begin
                    fcnt  <= '0;
                    level <= (level < target) ? level + 1'b1 : level - 1'b1;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            if (bus.fade_start && state == S_RUN)
                target <= (bus.fade_target > 5'd16) ? 5'd16 : bus.fade_target;
        end
    end

    assign bus.fade_busy = (level != target);
`else
    logic unused_fade;
    assign unused_fade   = ^{bus.frame_tick, bus.fade_start, bus.fade_target, (FADE_DIV > 0)};
    assign bus.fade_busy = 1'b0;
`endif

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [COLOR_W-1:0] c;
        logic [COLOR_W-1:0] scaled;
        logic [COLOR_W-1:0] q;
        assign c = s1_rgb[ch*COLOR_W +: COLOR_W];
`ifdef PALETTE_FADE_EN
        logic [COLOR_W+4:0] prod;
        assign prod   = c * level;
        assign scaled = COLOR_W'(prod >> 4);
`else
        assign scaled = c;
`endif
        always_ff @(posedge Clk) begin
            if (Reset) q <= '0;
            else       q <= scaled;
        end
        assign s2_rgb[ch] = q;
    end

    assign bus.rd_valid_out = vld_pipe[STAGES];
    assign bus.red          = s2_rgb[2];
    assign bus.green        = s2_rgb[1];
    assign bus.blue         = s2_rgb[0];
    assign bus.transparent  = transp_q;
    assign bus.init_busy    = (state == S_INIT);
endmodule
